mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
- Moore FSM control unit that sequences a multi-cycle MIPS datapath (shared instruction/data memory, IR, A/B/ALUOut registers).
- Decodes opCode/funct and drives the same mux/strobe encodings the datapath already uses: ALUcontrol, regWriteDataSel, regIn, pcSel, aluIn.
- Stretches fetch and load/store states on a memory-ready handshake.
- Sits between the datapath and the shared memory port.

Parameters:
- WAIT_LIMIT, 16: max consecutive cycles waiting on mem_ready before bus error.
- WAIT_W, 5: width of wait counter; must hold WAIT_LIMIT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- opCode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- ALUcontrol  out  2  0=add, 1=sub, 2=use funct, 3=slt
- regWriteDataSel  out  2  0=ALUOut, 1=MDR, 2=PC (link)
- regIn  out  2  0=rt, 1=rd, 2=$31
- pcSel  out  2  0=ALU result (PC+4), 1=jump target, 2=A (jr), 3=ALUOut (branch target)
- aluIn  out  1  ALU B = sign-extended imm
- IorD  out  1  memory address = ALUOut
- irWrite  out  1  load IR
- pcWrite  out  1  load PC
- memRead, memWrite, regWrite  out  1  strobes
- retire  out  1  one-cycle pulse on last cycle of each instruction
- bus_err  out  1  sticky memory timeout flag

Behaviour:
- State register reset asynchronously to IDLE. In IDLE all outputs are 0 except the recirculating state. IDLE->FETCH unconditionally on the next clk.
- Outputs are pure functions of state (plus zero in BRANCH); no glitch-sensitive decoding of mem_ready onto regWrite.
- FETCH: memRead=1, IorD=0, ALU computes PC+4 (aluIn=0, ALUcontrol=0).
  - mem_ready=1: irWrite=1, pcWrite=1, pcSel=0 -> DECODE.
  - Otherwise stay; irWrite and pcWrite stay 0 while waiting.
- DECODE: ALUOut <= PC + (imm<<2) (aluIn=1, ALUcontrol=0). Next state by opcode:
  - 0x00 with funct 0x08 -> JR
  - 0x00 other -> EXEC_R
  - 0x23 or 0x2B -> ADDR
  - 0x08 or 0x0A -> EXEC_I
  - 0x04 or 0x05 -> BRANCH
  - 0x02 -> JUMP
  - 0x03 -> JAL
  - other -> FETCH, counted as a retire (NOP), unless ILLEGAL_TRAP_EN.
- EXEC_R: ALUcontrol=2, aluIn=0 -> WB_R. WB_R: regWrite=1, regIn=1, regWriteDataSel=0, retire -> FETCH.
- EXEC_I: aluIn=1, ALUcontrol=0 (addi) or 3 (slti) -> WB_I. WB_I: regWrite=1, regIn=0, regWriteDataSel=0, retire -> FETCH.
- ADDR: aluIn=1, ALUcontrol=0 -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: IorD=1, memRead=1. Waits on mem_ready, then -> WB_MEM. WB_MEM: regWrite=1, regIn=0, regWriteDataSel=1, retire -> FETCH.
- MEM_WR: IorD=1, memWrite=1 held until mem_ready. On mem_ready: retire -> FETCH.
- BRANCH: ALUcontrol=1, aluIn=0, pcSel=3. pcWrite = zero for 0x04, !zero for 0x05. retire -> FETCH.
- JUMP: pcSel=1, pcWrite=1, retire -> FETCH.
- JAL: pcSel=1, pcWrite=1, regWrite=1, regIn=2, regWriteDataSel=2, retire -> FETCH. The link value is the already-incremented PC.
- JR: pcSel=2, pcWrite=1, retire -> FETCH.
- Wait counter:
  - Clears on entry to FETCH, MEM_RD or MEM_WR, and increments each waiting cycle.
  - When count reaches WAIT_LIMIT without mem_ready: bus_err<=1 and state -> HALT.
  - HALT: all strobes 0, stays until rst.
- bus_err clears only on rst.
- rst mid-instruction aborts immediately; no partial writes after rst asserts.
- Cycle counts with mem_ready tied 1: R/I-type 4, lw 5, sw 4, beq/bne/j/jal/jr 3.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an unrecognised opcode in DECODE -> HALT, with output illegal_op (1 bit, sticky, cleared by rst) set to 1. retire does not pulse.
- Undefined: the illegal_op port is absent, and unknown opcodes retire as a NOP.

Test Plan:
- Reset release, mem_ready=1, opCode=0x00, funct=0x20: IDLE, FETCH, DECODE, EXEC_R, WB_R. regWrite=1 and regIn=1 only in WB_R; retire pulses on cycle 5 after reset.
- lw (0x23) with mem_ready low 3 cycles in MEM_RD: memRead held 4 cycles, IorD=1. WB_MEM then has regWriteDataSel=1. Total 8 cycles fetch-to-retire.
- beq (0x04) with zero=1 -> pcWrite=1 and pcSel=3 in BRANCH. Same with zero=0 -> pcWrite=0. bne (0x05) gives the inverse.
- jal (0x03): JAL state drives regIn=2, regWriteDataSel=2, regWrite=1, pcSel=1, pcWrite=1. jr (0x00/0x08) drives pcSel=2, regWrite=0.
- mem_ready held 0 in FETCH for WAIT_LIMIT=16 cycles: bus_err=1, HALT, all strobes 0. Asserting rst clears bus_err and returns to IDLE.
- opCode=0x3F: without ILLEGAL_TRAP_EN, retire pulses and FETCH follows. With it defined, illegal_op=1, HALT, no retire.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// +----------------------------------------------------------------------------+
// | mips_multicycle_ctrl                                                       |
// | Moore control FSM for a multi-cycle MIPS datapath with a shared memory    |
// | port, mem_ready handshake, wait-timeout bus error and sticky HALT.        |
// | Optional: `define ILLEGAL_TRAP_EN to trap unknown opcodes (illegal_op).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mips_multicycle_ctrl #(
  parameter int WAIT_LIMIT = 16,
  parameter int WAIT_W     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opCode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] ALUcontrol,
  output logic [1:0] regWriteDataSel,
  output logic [1:0] regIn,
  output logic [1:0] pcSel,
  output logic       aluIn,
  output logic       IorD,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       memRead,
  output logic       memWrite,
  output logic       regWrite,
  output logic       retire,
`ifdef ILLEGAL_TRAP_EN
  output logic       illegal_op,
`endif
  output logic       bus_err
);

  localparam logic [3:0] c_S_IDLE   = 4'd0;
  localparam logic [3:0] c_S_FETCH  = 4'd1;
  localparam logic [3:0] c_S_DECODE = 4'd2;
  localparam logic [3:0] c_S_EXEC_R = 4'd3;
  localparam logic [3:0] c_S_WB_R   = 4'd4;
  localparam logic [3:0] c_S_EXEC_I = 4'd5;
  localparam logic [3:0] c_S_WB_I   = 4'd6;
  localparam logic [3:0] c_S_ADDR   = 4'd7;
  localparam logic [3:0] c_S_MEM_RD = 4'd8;
  localparam logic [3:0] c_S_WB_MEM = 4'd9;
  localparam logic [3:0] c_S_MEM_WR = 4'd10;
  localparam logic [3:0] c_S_BRANCH = 4'd11;
  localparam logic [3:0] c_S_JUMP   = 4'd12;
  localparam logic [3:0] c_S_JAL    = 4'd13;
  localparam logic [3:0] c_S_JR     = 4'd14;
  localparam logic [3:0] c_S_HALT   = 4'd15;

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_JAL   = 6'h03;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_SLTI  = 6'h0A;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;
  localparam logic [5:0] c_FN_JR    = 6'h08;

  localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

  logic [3:0]        r_state;
  logic [3:0]        w_state_next;
  logic [3:0]        w_decode_next;
  logic              w_known;
  logic              w_waiting;
  logic              w_timeout;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_bus_err;
`ifdef ILLEGAL_TRAP_EN
  logic              r_illegal_op;
`endif

  // Opcode decode; only meaningful while IR holds the fetched word (DECODE onward)
  always_comb begin
    w_known       = 1'b1;
    w_decode_next = c_S_FETCH;
    case (opCode)
      c_OP_RTYPE:       w_decode_next = (funct == c_FN_JR) ? c_S_JR : c_S_EXEC_R;
      c_OP_LW, c_OP_SW: w_decode_next = c_S_ADDR;
      c_OP_ADDI, c_OP_SLTI: w_decode_next = c_S_EXEC_I;
      c_OP_BEQ, c_OP_BNE:   w_decode_next = c_S_BRANCH;
      c_OP_J:           w_decode_next = c_S_JUMP;
      c_OP_JAL:         w_decode_next = c_S_JAL;
      default: begin
        w_known = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        w_decode_next = c_S_HALT;
`else
        w_decode_next = c_S_FETCH;
`endif
      end
    endcase
  end

  assign w_waiting = ((r_state == c_S_FETCH) || (r_state == c_S_MEM_RD) ||
                      (r_state == c_S_MEM_WR)) && !mem_ready;
  assign w_timeout = w_waiting && (r_wait_cnt == c_WAIT_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_S_IDLE:   w_state_next = c_S_FETCH;
      c_S_FETCH:  w_state_next = mem_ready ? c_S_DECODE : (w_timeout ? c_S_HALT : c_S_FETCH);
      c_S_DECODE: w_state_next = w_decode_next;
      c_S_EXEC_R: w_state_next = c_S_WB_R;
      c_S_WB_R:   w_state_next = c_S_FETCH;
      c_S_EXEC_I: w_state_next = c_S_WB_I;
      c_S_WB_I:   w_state_next = c_S_FETCH;
      c_S_ADDR:   w_state_next = (opCode == c_OP_SW) ? c_S_MEM_WR : c_S_MEM_RD;
      c_S_MEM_RD: w_state_next = mem_ready ? c_S_WB_MEM : (w_timeout ? c_S_HALT : c_S_MEM_RD);
      c_S_WB_MEM: w_state_next = c_S_FETCH;
      c_S_MEM_WR: w_state_next = mem_ready ? c_S_FETCH : (w_timeout ? c_S_HALT : c_S_MEM_WR);
      c_S_BRANCH: w_state_next = c_S_FETCH;
      c_S_JUMP:   w_state_next = c_S_FETCH;
      c_S_JAL:    w_state_next = c_S_FETCH;
      c_S_JR:     w_state_next = c_S_FETCH;
      c_S_HALT:   w_state_next = c_S_HALT;
      default:    w_state_next = c_S_IDLE;
    endcase
  end

  // Wait counter restarts on any state change, so it is zero on entry to each wait state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_S_IDLE;
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      r_illegal_op <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        r_wait_cnt <= '0;
      end else if (w_waiting) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_bus_err <= 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      if ((r_state == c_S_DECODE) && !w_known) begin
        r_illegal_op <= 1'b1;
      end
`endif
    end
  end

  assign bus_err = r_bus_err;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_op = r_illegal_op;
`endif

  // mem_ready only qualifies the fetch load strobes and the store retire, never regWrite
  always_comb begin
    ALUcontrol      = 2'd0;
    regWriteDataSel = 2'd0;
    regIn           = 2'd0;
    pcSel           = 2'd0;
    aluIn           = 1'b0;
    IorD            = 1'b0;
    irWrite         = 1'b0;
    pcWrite         = 1'b0;
    memRead         = 1'b0;
    memWrite        = 1'b0;
    regWrite        = 1'b0;
    retire          = 1'b0;
    case (r_state)
      c_S_FETCH: begin
        memRead = 1'b1;
        irWrite = mem_ready;
        pcWrite = mem_ready;
      end
      c_S_DECODE: begin
        aluIn = 1'b1;
`ifndef ILLEGAL_TRAP_EN
        retire = !w_known;
`endif
      end
      c_S_EXEC_R: ALUcontrol = 2'd2;
      c_S_WB_R: begin
        regWrite = 1'b1;
        regIn    = 2'd1;
        retire   = 1'b1;
      end
      c_S_EXEC_I: begin
        aluIn      = 1'b1;
        ALUcontrol = (opCode == c_OP_SLTI) ? 2'd3 : 2'd0;
      end
      c_S_WB_I: begin
        regWrite = 1'b1;
        retire   = 1'b1;
      end
      c_S_ADDR: aluIn = 1'b1;
      c_S_MEM_RD: begin
        IorD    = 1'b1;
        memRead = 1'b1;
      end
      c_S_WB_MEM: begin
        regWrite        = 1'b1;
        regWriteDataSel = 2'd1;
        retire          = 1'b1;
      end
      c_S_MEM_WR: begin
        IorD     = 1'b1;
        memWrite = 1'b1;
        retire   = mem_ready;
      end
      c_S_BRANCH: begin
        ALUcontrol = 2'd1;
        pcSel      = 2'd3;
        pcWrite    = (opCode == c_OP_BNE) ? !zero : zero;
        retire     = 1'b1;
      end
      c_S_JUMP: begin
        pcSel   = 2'd1;
        pcWrite = 1'b1;
        retire  = 1'b1;
      end
      c_S_JAL: begin
        pcSel           = 2'd1;
        pcWrite         = 1'b1;
        regWrite        = 1'b1;
        regIn           = 2'd2;
        regWriteDataSel = 2'd2;
        retire          = 1'b1;
      end
      c_S_JR: begin
        pcSel   = 2'd2;
        pcWrite = 1'b1;
        retire  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
